pipelined_rca_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. The WIDTH-bit operand is split into STAGES equal segments. Each segment is a short ripple chain, and its carry is registered into the next segment one cycle later. A valid/ready handshake with full back-pressure wraps the pipeline. It supersedes the fixed 8-bit combinational adder in datapaths where wide operands must close timing at the system clock.

---
 rtl/pipelined_rca_adder_pkg.sv | 20 ++
 rtl/pipelined_rca_adder_rca_segment.sv | 24 ++
 rtl/pipelined_rca_adder.sv | 159 +++++++++++++++
 tb/tb_pipelined_rca_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_rca_adder_pkg.sv
// Shared constants, segment sizing and stage-record type for the pipelined ripple-carry adder.
package pipelined_rca_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Full-width view of one pipeline stage at the default configuration (debug/monitor use).
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] a_rem;
        logic [DEFAULT_WIDTH-1:0] b_rem;
        logic                     carry;
        logic [DEFAULT_WIDTH-1:0] psum;
    } rca_stage_t;

endpackage

// File: rtl/pipelined_rca_adder_rca_segment.sv
// rca_segment: combinational SEG-bit ripple chain built from full-adder cells.
module rca_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic [SEG:0] c;
    genvar gi;

    assign c[0] = ci;

    for (gi = 0; gi < SEG; gi++) begin : fa_g
        assign s[gi]     = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co = c[SEG];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready back-pressure.
// Optional signed-overflow output enabled by defining PIPELINED_RCA_OVERFLOW_EN.
module pipelined_rca_adder
    import pipelined_rca_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0 || STAGES > WIDTH) begin : g_param_check
        $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES and STAGES <= WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    always_comb begin
        advance = !out_valid || out_ready;
        b_eff   = sub ? ~i2 : i2;
        c0      = cin ^ sub;
    end

    assign in_ready = advance;

    genvar gi;

    for (gi = 0; gi < STAGES; gi++) begin : stage_g
        localparam int PW  = (gi + 1) * SEG;
        localparam int REM = WIDTH - PW;

        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_s;
        logic           seg_ci;
        logic           seg_co;
        logic           valid_d, valid_q;
        logic           carry_d, carry_q;
        logic [PW-1:0]  psum_d, psum_q;

        if (gi == 0) begin : head_g
            always_comb begin
                seg_a   = i1[SEG-1:0];
                seg_b   = b_eff[SEG-1:0];
                seg_ci  = c0;
                valid_d = in_valid;
            end
            always_comb begin
                psum_d  = seg_s;
                carry_d = seg_co;
            end
        end else begin : body_g
            always_comb begin
                seg_a   = stage_g[gi-1].skew_g.a_q[SEG-1:0];
                seg_b   = stage_g[gi-1].skew_g.b_q[SEG-1:0];
                seg_ci  = stage_g[gi-1].carry_q;
                valid_d = stage_g[gi-1].valid_q;
            end
            // Completed lower segments ride along so every segment leaves together.
            always_comb begin
                psum_d  = {seg_s, stage_g[gi-1].psum_q};
                carry_d = seg_co;
            end
        end

        rca_segment #(.SEG(SEG)) u_seg (
            .a  (seg_a),
            .b  (seg_b),
            .ci (seg_ci),
            .s  (seg_s),
            .co (seg_co)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                psum_q  <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                psum_q  <= psum_d;
            end
        end

        // Skew: operand bits not yet consumed, shrinking by one segment per stage.
        if (REM > 0) begin : skew_g
            logic [REM-1:0] a_d, a_q;
            logic [REM-1:0] b_d, b_q;

            if (gi == 0) begin : src_g
                always_comb begin
                    a_d = i1[WIDTH-1:SEG];
                    b_d = b_eff[WIDTH-1:SEG];
                end
            end else begin : src_g
                always_comb begin
                    a_d = stage_g[gi-1].skew_g.a_q[REM+SEG-1:SEG];
                    b_d = stage_g[gi-1].skew_g.b_q[REM+SEG-1:SEG];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign out_valid = stage_g[STAGES-1].valid_q;
    assign Sum       = stage_g[STAGES-1].psum_q;
    assign Carry     = stage_g[STAGES-1].carry_q;

`ifdef PIPELINED_RCA_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    always_comb begin
        ovf_d = stage_g[STAGES-1].seg_co
              ^ (stage_g[STAGES-1].seg_a[SEG-1]
               ^ stage_g[STAGES-1].seg_b[SEG-1]
               ^ stage_g[STAGES-1].seg_s[SEG-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed-vector bench for pipelined_rca_adder (WIDTH=16, STAGES=4): latency, arithmetic, stall, reset.
module tb_pipelined_rca_adder;

    localparam int W = 16;
    localparam int S = 4;
`ifdef PIPELINED_RCA_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, Carry, Ovf;
    logic [W-1:0] i1, i2, Sum;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];
    logic         qs[$];
    logic [W+1:0] qexp[$];

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i1        (i1),
        .i2        (i2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Carry     (Carry),
        .Ovf       (Ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, carry, sum} from the arithmetic definition.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         ov;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c ^ s};
        ov = OVF_EN && (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r};
    endfunction

    task automatic run_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s,
                            input logic [W-1:0] esum, input logic ecarry, input logic eovf);
        int cyc;
        i1 = a; i2 = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(S));
        chk({tag, "_sum"}, 32'(Sum), 32'(esum));
        chk({tag, "_carry"}, 32'(Carry), 32'(ecarry));
        chk({tag, "_ovf"}, 32'(Ovf), 32'(eovf));
        $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h carry=%0d ovf=%0d lat=%0d",
                 tag, a, b, c, s, Sum, Carry, Ovf, cyc);
        @(posedge clk); #1;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    // Streams the queued beats at full rate; out_ready is low for cycles stall_lo..stall_hi.
    task automatic stream(input string tag, input int stall_lo, input int stall_hi);
        int           t = 0;
        int           got = 0;
        int           total;
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_sum = '0;
        logic         prev_carry = 1'b0;
        logic [W+1:0] e;
        total = qa.size();
        while (got < total && t < 200) begin
            if (qa.size() > 0) begin
                in_valid = 1'b1; i1 = qa[0]; i2 = qb[0]; cin = qc[0]; sub = qs[0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(t >= stall_lo && t <= stall_hi);
            #1;
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_sum"}, 32'(Sum), 32'(prev_sum));
                chk({tag, "_hold_carry"}, 32'(Carry), 32'(prev_carry));
            end
            chk({tag, "_in_ready"}, 32'(in_ready), 32'(!out_valid || out_ready));
            prev_stall = out_valid && !out_ready;
            prev_sum   = Sum;
            prev_carry = Carry;
            if (out_valid && out_ready) begin
                if (qexp.size() == 0) begin
                    chk({tag, "_extra_beat"}, 32'd1, 32'd0);
                end else begin
                    e = qexp.pop_front();
                    chk({tag, "_sum"}, 32'(Sum), 32'(e[W-1:0]));
                    chk({tag, "_carry"}, 32'(Carry), 32'(e[W]));
                    chk({tag, "_ovf"}, 32'(Ovf), 32'(e[W+1]));
                    $display("txn %s #%0d t=%0d sum=%h carry=%0d ovf=%0d", tag, got, t, Sum, Carry, Ovf);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                void'(qa.pop_front()); void'(qb.pop_front());
                void'(qc.pop_front()); void'(qs.pop_front());
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 32'(got), 32'(total));
        #1;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        qa.delete(); qb.delete(); qc.delete(); qs.delete(); qexp.delete();
    endtask

    initial begin
        int extra;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        i1 = '0; i2 = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_carry", 32'(Carry), 32'd0);
        chk("rst_ovf", 32'(Ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        run_beat("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_beat("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_beat("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_EN);
        run_beat("sub_0005_0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_beat("sub_0007_0005_c1", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_beat("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_EN);
        run_beat("add_a5a5_5a5a_c1", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        for (int n = 1; n <= 8; n++) begin
            qa.push_back(16'(n));
            qb.push_back(16'(n << 12));
            qc.push_back(1'b0);
            qs.push_back(1'b0);
            qexp.push_back({1'b0, 1'b0, 16'(n * 16'h1001)});
        end
        stream("stall", 5, 7);

        for (int n = 0; n < 16; n++) begin
            ra = 16'($urandom()); rb = 16'($urandom());
            rc = 1'($urandom()); rs = 1'($urandom());
            qa.push_back(ra); qb.push_back(rb); qc.push_back(rc); qs.push_back(rs);
            qexp.push_back(model(ra, rb, rc, rs));
        end
        stream("rand", 3, 4);

        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; i1 = 16'h0F0F; i2 = 16'(16'h1111 * (n + 1)); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(Sum), 32'd0);
        chk("midrst_carry", 32'(Carry), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_beat("after_rst_1234_1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        extra = 0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        chk("after_rst_no_stale", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
